tx_gearbox_feeder: RTL and testbench

TX_GEARBOX_FEEDER -- requirements
Module: tx_gearbox_feeder

---
 rtl/tx_gearbox_feeder.sv | 103 ++++++++++
 tb/tb_tx_gearbox_feeder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_gearbox_feeder.sv
// Feeds 64b/66b blocks to a 66b-to-64b gearbox as 32-bit halves on a 66-cycle frame.
// Holds a 2-entry block FIFO, optionally scrambles payloads, and inserts idle blocks on underflow.
module tx_gearbox_feeder #(
    parameter bit          SCRAMBLE_EN  = 1'b1,
    parameter logic [63:0] IDLE_PAYLOAD = 64'h0000_0000_0000_001E
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] s_data_i,
    input  logic [1:0]  s_head_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [31:0] data_o,
    output logic [1:0]  head_o,
    output logic [6:0]  sequence_o,
    output logic        underflow_o
);

    // Handshake: a block is accepted on a rising edge where s_valid_i and s_ready_o are both 1.
    logic [65:0] fifo_mem [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count_q, count_d;
    logic [6:0]  seq_q, seq_d;
    logic [57:0] scr_q, scr_next;
    logic [31:0] hi_q;
    logic [63:0] scr_out;
    logic [63:0] blk_data;
    logic [1:0]  blk_head;
    logic        push, pop, idle, block_start, second_half;

    assign push        = s_valid_i & s_ready_o;
    assign seq_d       = (seq_q == 7'd65) ? 7'd0 : seq_q + 7'd1;
    assign block_start = ~seq_d[6] & ~seq_d[0];
    assign second_half = ~seq_d[6] & seq_d[0];
    assign pop         = block_start & (count_q != 2'd0);
    assign idle        = block_start & (count_q == 2'd0);
    assign blk_head    = idle ? 2'b10 : fifo_mem[rd_ptr][65:64];
    assign blk_data    = idle ? IDLE_PAYLOAD : fifo_mem[rd_ptr][63:0];
    assign count_d     = count_q + {1'b0, push} - {1'b0, pop};
    assign sequence_o  = seq_q;

    // Serial self-synchronous scrambler unrolled over the whole 64-bit payload.
    always_comb begin : scramble
        logic [57:0] s;
        logic [63:0] o;
        s = scr_q;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            o[i] = blk_data[i] ^ s[38] ^ s[57];
            s    = {s[56:0], o[i]};
        end
        scr_out  = blk_data;
        scr_next = scr_q;
        if (SCRAMBLE_EN) begin
            scr_out  = o;
            scr_next = s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s_head_i, s_data_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seq_q       <= 7'd65;
            count_q     <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            s_ready_o   <= 1'b0;
            scr_q       <= '1;
            hi_q        <= '0;
            data_o      <= '0;
            head_o      <= 2'b10;
            underflow_o <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            count_q     <= count_d;
            s_ready_o   <= (count_d < 2'd2);
            underflow_o <= idle;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Upper half is parked in hi_q so it comes from the same scrambler pass.
            if (block_start) begin
                data_o <= scr_out[31:0];
                hi_q   <= scr_out[63:32];
                head_o <= blk_head;
                scr_q  <= scr_next;
            end else if (second_half) begin
                data_o <= hi_q;
            end else begin
                data_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tx_gearbox_feeder.sv
// Bench for tx_gearbox_feeder: scrambled and bypass instances share one stimulus stream,
// and a block queue plus a G(x)=1+x^39+x^58 reference predicts every output cycle.
module tb_tx_gearbox_feeder;

    localparam logic [63:0] IDLE = 64'h0000_0000_0000_001E;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] s_data = '0;
    logic [1:0]  s_head = '0;
    logic        s_valid = 1'b0;

    logic        ready_a, ready_b, uf_a, uf_b;
    logic [31:0] data_a, data_b;
    logic [1:0]  head_a, head_b;
    logic [6:0]  seq_a, seq_b;

    always #5 clk = ~clk;

    tx_gearbox_feeder #(.SCRAMBLE_EN(1'b1), .IDLE_PAYLOAD(IDLE)) dut_scr (
        .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_head_i(s_head),
        .s_valid_i(s_valid), .s_ready_o(ready_a), .data_o(data_a),
        .head_o(head_a), .sequence_o(seq_a), .underflow_o(uf_a)
    );

    tx_gearbox_feeder #(.SCRAMBLE_EN(1'b0), .IDLE_PAYLOAD(IDLE)) dut_raw (
        .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_head_i(s_head),
        .s_valid_i(s_valid), .s_ready_o(ready_b), .data_o(data_b),
        .head_o(head_b), .sequence_o(seq_b), .underflow_o(uf_b)
    );

    int          vectors = 0;
    int          errors = 0;
    logic [65:0] exp_q[$];
    logic [6:0]  exp_seq;
    bit          first;
    bit          pend;
    logic [65:0] pend_blk;
    logic        hist[$];
    logic [57:0] dsc_s;
    logic [31:0] hi_scr, hi_raw;
    logic [1:0]  last_head;
    int          uf_cnt = 0, acc_cnt = 0, pop_cnt = 0;
    bit          saw_not_ready;

    task automatic reseed();
        hist.delete();
        repeat (58) hist.push_back(1'b1);
        dsc_s = '1;
    endtask

    // Reference: out_n = in_n ^ out_(n-39) ^ out_(n-58); hist holds the last 58 outputs, oldest first.
    task automatic scramble64(input logic [63:0] d, output logic [63:0] o);
        for (int i = 0; i < 64; i++) begin
            o[i] = d[i] ^ hist[19] ^ hist[0];
            hist.push_back(o[i]);
            void'(hist.pop_front());
        end
    endtask

    task automatic descramble32(input logic [31:0] obs, output logic [31:0] rec);
        for (int i = 0; i < 32; i++) begin
            rec[i] = obs[i] ^ dsc_s[38] ^ dsc_s[57];
            dsc_s  = {dsc_s[56:0], obs[i]};
        end
    endtask

    task automatic check_outputs();
        logic [65:0] blk;
        logic [63:0] scr;
        logic [31:0] rec;
        logic        exp_uf;
        exp_seq = first ? 7'd0 : ((exp_seq == 7'd65) ? 7'd0 : exp_seq + 7'd1);
        first = 1'b0;
        vectors++;
        if (seq_a !== exp_seq || seq_b !== exp_seq) begin
            errors++;
            $display("FAIL sequence: got %0d/%0d want %0d", seq_a, seq_b, exp_seq);
        end
        if (exp_seq < 7'd64 && !exp_seq[0]) begin
            if (exp_q.size() == 0) begin
                blk = {2'b10, IDLE};
                exp_uf = 1'b1;
            end else begin
                blk = exp_q.pop_front();
                exp_uf = 1'b0;
                pop_cnt++;
            end
            scramble64(blk[63:0], scr);
            hi_scr = scr[63:32];
            hi_raw = blk[63:32];
            last_head = blk[65:64];
            vectors += 4;
            if (data_a !== scr[31:0]) begin
                errors++;
                $display("FAIL scr_lo seq %0d: got %h want %h", exp_seq, data_a, scr[31:0]);
            end
            if (data_b !== blk[31:0]) begin
                errors++;
                $display("FAIL raw_lo seq %0d: got %h want %h", exp_seq, data_b, blk[31:0]);
            end
            if (head_a !== blk[65:64] || head_b !== blk[65:64]) begin
                errors++;
                $display("FAIL head seq %0d: got %b/%b want %b", exp_seq, head_a, head_b, blk[65:64]);
            end
            if (uf_a !== exp_uf || uf_b !== exp_uf) begin
                errors++;
                $display("FAIL underflow seq %0d: got %b/%b want %b", exp_seq, uf_a, uf_b, exp_uf);
            end
            descramble32(data_a, rec);
            vectors++;
            if (rec !== blk[31:0]) begin
                errors++;
                $display("FAIL descr_lo seq %0d: got %h want %h", exp_seq, rec, blk[31:0]);
            end
        end else if (exp_seq < 7'd64) begin
            vectors += 3;
            if (data_a !== hi_scr || data_b !== hi_raw) begin
                errors++;
                $display("FAIL hi seq %0d: got %h/%h want %h/%h", exp_seq, data_a, data_b, hi_scr, hi_raw);
            end
            if (head_a !== last_head || head_b !== last_head || uf_a !== 1'b0 || uf_b !== 1'b0) begin
                errors++;
                $display("FAIL hi_ctrl seq %0d: head %b/%b uf %b/%b want head %b uf 0",
                         exp_seq, head_a, head_b, uf_a, uf_b, last_head);
            end
            descramble32(data_a, rec);
            if (rec !== hi_raw) begin
                errors++;
                $display("FAIL descr_hi seq %0d: got %h want %h", exp_seq, rec, hi_raw);
            end
        end else begin
            vectors++;
            if (data_a !== 32'd0 || data_b !== 32'd0 || head_a !== last_head || head_b !== last_head
                || uf_a !== 1'b0 || uf_b !== 1'b0) begin
                errors++;
                $display("FAIL pause seq %0d: data %h/%h head %b/%b uf %b/%b want 0 head %b uf 0",
                         exp_seq, data_a, data_b, head_a, head_b, uf_a, uf_b, last_head);
            end
        end
        if (uf_a) uf_cnt++;
    endtask

    // Called at a falling edge: drives inputs for the next rising edge and checks its results.
    task automatic tick(input logic v, input logic [1:0] h, input logic [63:0] d);
        logic exp_r;
        s_valid = v;
        s_head = h;
        s_data = d;
        pend = v && ready_a;
        pend_blk = {h, d};
        if (pend) acc_cnt++;
        @(negedge clk);
        check_outputs();
        if (pend) exp_q.push_back(pend_blk);
        exp_r = (exp_q.size() < 2);
        vectors++;
        if (ready_a !== exp_r || ready_b !== exp_r) begin
            errors++;
            $display("FAIL ready seq %0d: got %b/%b want %b", exp_seq, ready_a, ready_b, exp_r);
        end
        if (!ready_a) saw_not_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        #1;
        vectors++;
        if (seq_a !== 7'd65 || seq_b !== 7'd65 || data_a !== 32'd0 || data_b !== 32'd0
            || head_a !== 2'b10 || head_b !== 2'b10 || uf_a !== 1'b0 || uf_b !== 1'b0
            || ready_a !== 1'b0 || ready_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: seq %0d data %h head %b uf %b ready %b", seq_a, data_a, head_a, uf_a, ready_a);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (seq_a !== 7'd65 || seq_b !== 7'd65 || ready_a !== 1'b0 || ready_b !== 1'b0 || data_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold: seq %0d ready %b data %h want 65 0 0", seq_a, ready_a, data_a);
        end
        exp_q.delete();
        reseed();
        pend = 1'b0;
        first = 1'b1;
        last_head = 2'b10;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        do_reset();
    endtask

    task automatic test_single_block();
        logic [63:0] blk = 64'h1122334455667788;
        int p0 = pop_cnt;
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 5) begin
            tick(1'b1, 2'b01, blk);
            got = pend;
            n++;
        end
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL single_accept: got none want accepted within 5 cycles");
        end
        tick(1'b0, 2'b00, 64'd0);
        vectors++;
        if (data_b !== 32'h55667788 || head_b !== 2'b01 || uf_b !== 1'b0) begin
            errors++;
            $display("FAIL single_lo: got %h %b want 55667788 01", data_b, head_b);
        end
        tick(1'b0, 2'b00, 64'd0);
        vectors++;
        if (data_b !== 32'h11223344 || head_b !== 2'b01) begin
            errors++;
            $display("FAIL single_hi: got %h %b want 11223344 01", data_b, head_b);
        end
        repeat (70) tick(1'b0, 2'b00, 64'd0);
        vectors++;
        if (pop_cnt - p0 != 1) begin
            errors++;
            $display("FAIL single_count: got %0d want 1", pop_cnt - p0);
        end
    endtask

    task automatic test_idle();
        int u0 = uf_cnt;
        repeat (66) tick(1'b0, 2'b00, 64'd0);
        vectors++;
        if (uf_cnt - u0 != 32) begin
            errors++;
            $display("FAIL idle_underflows: got %0d want 32", uf_cnt - u0);
        end
    endtask

    task automatic test_full_rate();
        int a0, u0;
        repeat (66) tick(1'b1, 2'($urandom_range(1, 2)), {$urandom, $urandom});
        a0 = acc_cnt;
        u0 = uf_cnt;
        saw_not_ready = 1'b0;
        repeat (66) tick(1'b1, 2'($urandom_range(1, 2)), {$urandom, $urandom});
        vectors += 3;
        if (acc_cnt - a0 != 32) begin
            errors++;
            $display("FAIL full_accepts: got %0d want 32", acc_cnt - a0);
        end
        if (uf_cnt - u0 != 0) begin
            errors++;
            $display("FAIL full_underflows: got %0d want 0", uf_cnt - u0);
        end
        if (!saw_not_ready) begin
            errors++;
            $display("FAIL full_backpressure: got ready always 1 want a 0");
        end
    endtask

    task automatic test_scramble();
        repeat (200) tick(1'($urandom_range(0, 99) < 50), 2'($urandom_range(1, 2)), {$urandom, $urandom});
        repeat (70) tick(1'b0, 2'b00, 64'd0);
    endtask

    task automatic test_mid_reset();
        int n = 0;
        int u0;
        while (seq_a !== 7'd17 && n < 200) begin
            tick(1'b1, 2'b01, {32'hDEAD_BEEF, 32'(n)});
            n++;
        end
        vectors++;
        if (seq_a !== 7'd17) begin
            errors++;
            $display("FAIL midreset_reach: got %0d want 17", seq_a);
        end
        #2;
        do_reset();
        u0 = uf_cnt;
        repeat (66) tick(1'b0, 2'b00, 64'd0);
        vectors++;
        if (uf_cnt - u0 != 32) begin
            errors++;
            $display("FAIL midreset_idles: got %0d want 32", uf_cnt - u0);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a = 64'hA5A5_0001_A5A5_0002;
        logic [63:0] b = 64'h5A5A_0003_5A5A_0004;
        int n = 0;
        while (seq_a !== 7'd63 && n < 70) begin
            tick(1'b0, 2'b00, 64'd0);
            n++;
        end
        tick(1'b1, 2'b01, a);
        tick(1'b0, 2'b00, 64'd0);
        tick(1'b1, 2'b10, b);
        vectors += 2;
        if (data_b !== a[31:0] || uf_b !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got %h uf %b want %h uf 0", data_b, uf_b, a[31:0]);
        end
        if (ready_b !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b want 1", ready_b);
        end
        tick(1'b0, 2'b00, 64'd0);
        tick(1'b0, 2'b00, 64'd0);
        vectors++;
        if (data_b !== b[31:0] || head_b !== 2'b10 || uf_b !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got %h %b uf %b want %h 10 uf 0", data_b, head_b, uf_b, b[31:0]);
        end
        repeat (8) tick(1'b0, 2'b00, 64'd0);
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_idle();
        test_full_rate();
        test_scramble();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
